// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and carry-cleanup helper shared by the ALU arbiter
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_EQ   = 3'b101,
    ALU_NEQ  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  function automatic logic carry_op(input logic [2:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_PASS};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter with optional fixed core0 priority
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic [1:0] gnt_o,
  output logic       winner_o
);
  assign winner_o = &req_i ? (fixed_i ? 1'b0 : ~last_i) : req_i[1];
  assign gnt_o    = |req_i ? (winner_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two cores with req/ack and registered operands
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_W     = 3,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [WIDTH-1:0]  a0_i,
  input  logic [WIDTH-1:0]  b0_i,
  input  logic [WIDTH-1:0]  a1_i,
  input  logic [WIDTH-1:0]  b1_i,
  input  logic [CTRL_W-1:0] ctrl0_i,
  input  logic [CTRL_W-1:0] ctrl1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              rsp_valid0_o,
  output logic              rsp_valid1_o,
  output logic [WIDTH-1:0]  rsp_data0_o,
  output logic [WIDTH-1:0]  rsp_data1_o,
  output logic              rsp_cout0_o,
  output logic              rsp_cout1_o,
  output logic [WIDTH-1:0]  alu_a_o,
  output logic [WIDTH-1:0]  alu_b_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [WIDTH-1:0]  alu_c_i,
  input  logic              alu_cout_i
);
  state_e state_q, state_d;
  logic last_q, last_d, owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;
  logic rsp_cout0_q, rsp_cout0_d, rsp_cout1_q, rsp_cout1_d;
  logic [1:0] gnt;
  logic winner, take, cap, cout_clean;
  rr_arb2 u_arb (
    .req_i   ({req1_i, req0_i}),
    .last_i  (last_q),
    .fixed_i (FIXED_PRIO),
    .gnt_o   (gnt),
    .winner_o(winner)
  );
  always_comb begin
    take        = (state_q != S_EXEC) && (req0_i || req1_i);
    cap         = state_q == S_EXEC;
    cout_clean  = carry_op(3'(alu_ctrl_q)) ? alu_cout_i : 1'b0;
    state_d     = take ? S_EXEC : (cap ? S_RESP : S_IDLE);
    last_d      = take ? winner : last_q;
    owner_d     = take ? winner : owner_q;
    alu_a_d     = take ? (winner ? a1_i : a0_i) : alu_a_q;
    alu_b_d     = take ? (winner ? b1_i : b0_i) : alu_b_q;
    alu_ctrl_d  = take ? (winner ? ctrl1_i : ctrl0_i) : alu_ctrl_q;
    rsp_data0_d = (cap && !owner_q) ? alu_c_i : rsp_data0_q;
    rsp_cout0_d = (cap && !owner_q) ? cout_clean : rsp_cout0_q;
    rsp_data1_d = (cap && owner_q) ? alu_c_i : rsp_data1_q;
    rsp_cout1_d = (cap && owner_q) ? cout_clean : rsp_cout1_q;
  end
  // ack is suppressed during reset so a core never sees an accept that gets discarded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= CTRL_W'(ALU_PASS);
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      rsp_cout0_q <= 1'b0;
      rsp_cout1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_cout0_q <= rsp_cout0_d;
      rsp_cout1_q <= rsp_cout1_d;
    end
  end
  assign ack0_o       = rst_n && take && gnt[0];
  assign ack1_o       = rst_n && take && gnt[1];
  assign rsp_valid0_o = (state_q == S_RESP) && !owner_q;
  assign rsp_valid1_o = (state_q == S_RESP) && owner_q;
  assign rsp_data0_o  = rsp_data0_q;
  assign rsp_data1_o  = rsp_data1_q;
  assign rsp_cout0_o  = rsp_cout0_q;
  assign rsp_cout1_o  = rsp_cout1_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_ctrl_o   = alu_ctrl_q;
endmodule
